// File: rtl/edge_capture_bank.sv
`default_nettype none
// ============================================================================
// Module   : edge_capture_bank
// Purpose  : Per-channel synchroniser, debounce and edge qualification with
//            sticky W1C pending/overrun flags and an OR-reduced interrupt.
// Revision : 1.0
// ============================================================================
module edge_capture_bank #(
    parameter int CHANNELS        = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   a_i,
    input  logic [2*CHANNELS-1:0] mode_i,
    input  logic [CHANNELS-1:0]   clear_i,
    output logic [CHANNELS-1:0]   level_o,
    output logic [CHANNELS-1:0]   pulse_o,
    output logic [CHANNELS-1:0]   pending_o,
    output logic [CHANNELS-1:0]   overrun_o,
    output logic                  irq_o
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_CNT_W-1:0]     r_cnt;
        logic                   r_level;
        logic                   r_pulse;
        logic                   r_pending;
        logic                   r_overrun;
        logic [1:0]             w_mode;
        logic                   w_sync_out;
        logic                   w_accept;
        logic                   w_qual;
        logic                   w_ovr_set;

        assign w_sync_out = r_sync[SYNC_STAGES-1];
        assign w_mode     = mode_i[2*gi +: 2];
        // A transition is accepted on the edge that loads the new level, so
        // pulse and flags become visible together with level_o.
        assign w_accept   = (w_sync_out != r_level) && (r_cnt == c_CNT_MAX);
        assign w_qual     = (w_accept &  w_sync_out & w_mode[0]) |
                            (w_accept & ~w_sync_out & w_mode[1]);
        assign w_ovr_set  = w_qual & r_pending & ~clear_i[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], a_i[gi]};
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else if (w_sync_out == r_level) begin
                r_cnt   <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_cnt   <= '0;
                r_level <= w_sync_out;
            end else begin
                r_cnt   <= r_cnt + c_CNT_ONE;
            end
        end

        // Set has priority over the same-cycle clear strobe.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pulse   <= 1'b0;
                r_pending <= 1'b0;
                r_overrun <= 1'b0;
            end else begin
                r_pulse   <= w_qual;
                r_pending <= w_qual | (r_pending & ~clear_i[gi]);
                r_overrun <= w_ovr_set | (r_overrun & ~clear_i[gi]);
            end
        end

        assign level_o[gi]   = r_level;
        assign pulse_o[gi]   = r_pulse;
        assign pending_o[gi] = r_pending;
        assign overrun_o[gi] = r_overrun;
    end

    assign irq_o = |pending_o;

endmodule
`default_nettype wire

// File: tb/tb_edge_capture_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_edge_capture_bank
// Purpose  : Directed scoreboard bench for edge_capture_bank (default params).
// Revision : 1.0
// ============================================================================
module tb_edge_capture_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a_i;
    logic [15:0] mode_i;
    logic [7:0]  clear_i;
    logic [7:0]  level_o;
    logic [7:0]  pulse_o;
    logic [7:0]  pending_o;
    logic [7:0]  overrun_o;
    logic        irq_o;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         cyc;
        logic [7:0] pulse;
        logic [7:0] level;
        logic [7:0] pending;
        logic [7:0] overrun;
    } exp_t;

    exp_t sb[$];

    edge_capture_bank #(
        .CHANNELS        (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_i       (a_i),
        .mode_i    (mode_i),
        .clear_i   (clear_i),
        .level_o   (level_o),
        .pulse_o   (pulse_o),
        .pending_o (pending_o),
        .overrun_o (overrun_o),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse pops one expectation; overdue expectations are misses.
    always @(negedge clk) begin
        exp_t e;
        if (pulse_o !== 8'h00) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {24'h0, pulse_o}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_vec", {24'h0, pulse_o}, {24'h0, e.pulse});
                chk("level_at_pulse", {24'h0, level_o}, {24'h0, e.level});
                chk("pending_at_pulse", {24'h0, pending_o}, {24'h0, e.pending});
                chk("overrun_at_pulse", {24'h0, overrun_o}, {24'h0, e.overrun});
                chk("irq_at_pulse", {31'h0, irq_o}, {31'h0, |e.pending});
            end
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missing_pulse", 32'h0, {24'h0, e.pulse});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        mode_i[2*ch +: 2] = m;
    endtask

    // Called right after an input change: the pulse is due five edges after
    // the next edge, i.e. when cyc reaches now+6.
    task automatic expect_pulse(input logic [7:0] p, input logic [7:0] lv,
                                input logic [7:0] pd, input logic [7:0] ov);
        exp_t e;
        e.cyc = cyc + 6; e.pulse = p; e.level = lv; e.pending = pd; e.overrun = ov;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) tick(1);
        chk("scoreboard_drained", sb.size(), 0);
        tick(4);
    endtask

    task automatic do_clear(input logic [7:0] m);
        clear_i = m;
        tick(1);
        clear_i = 8'h00;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] lv, input logic [7:0] pd,
                             input logic [7:0] ov);
        chk({tag, "_level"}, {24'h0, level_o}, {24'h0, lv});
        chk({tag, "_pending"}, {24'h0, pending_o}, {24'h0, pd});
        chk({tag, "_overrun"}, {24'h0, overrun_o}, {24'h0, ov});
        chk({tag, "_irq"}, {31'h0, irq_o}, {31'h0, |pd});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        a_i     = 8'h01;
        mode_i  = 16'h0000;
        clear_i = 8'h00;
        set_mode(0, 2'b01);
        set_mode(2, 2'b01);

        // Reset values, then a high input held through reset acts as a rise.
        tick(3);
        chk_state("reset", 8'h00, 8'h00, 8'h00);
        chk("reset_pulse", {24'h0, pulse_o}, 32'h0);
        rst_n = 1'b1;
        expect_pulse(8'h01, 8'h01, 8'h01, 8'h00);
        drain();
        chk("reset_high_irq", {31'h0, irq_o}, 32'h1);
        do_clear(8'h01);
        chk_state("clr0", 8'h01, 8'h00, 8'h00);

        // Glitch of 3 cycles rejected; exactly 4 cycles accepted.
        a_i[2] = 1'b1; tick(3); a_i[2] = 1'b0;
        tick(12);
        chk_state("glitch", 8'h01, 8'h00, 8'h00);
        a_i[2] = 1'b1;
        expect_pulse(8'h04, 8'h05, 8'h04, 8'h00);
        tick(4); a_i[2] = 1'b0;
        drain();
        tick(6);
        chk_state("accept4", 8'h01, 8'h04, 8'h00);
        do_clear(8'h04);

        // Mode 10: only the fall qualifies.
        set_mode(1, 2'b10);
        a_i[1] = 1'b1; tick(10);
        chk_state("m10_rise", 8'h03, 8'h00, 8'h00);
        a_i[1] = 1'b0;
        expect_pulse(8'h02, 8'h01, 8'h02, 8'h00);
        drain();
        do_clear(8'h02);

        // Mode 11: both edges; the second without a clear overruns.
        set_mode(1, 2'b11);
        a_i[1] = 1'b1;
        expect_pulse(8'h02, 8'h03, 8'h02, 8'h00);
        drain(); tick(1);
        a_i[1] = 1'b0;
        expect_pulse(8'h02, 8'h01, 8'h02, 8'h02);
        drain();
        do_clear(8'h02);
        chk_state("m11_clr", 8'h01, 8'h00, 8'h00);

        // Mode 00: level follows, no pulse, no pending.
        set_mode(1, 2'b00);
        a_i[1] = 1'b1; tick(10);
        chk_state("m00_rise", 8'h03, 8'h00, 8'h00);
        a_i[1] = 1'b0; tick(10);
        chk_state("m00_fall", 8'h01, 8'h00, 8'h00);

        // Overrun on ch3, clear, then clear colliding with a new pulse.
        set_mode(3, 2'b11);
        a_i[3] = 1'b1;
        expect_pulse(8'h08, 8'h09, 8'h08, 8'h00);
        drain(); tick(1);
        a_i[3] = 1'b0;
        expect_pulse(8'h08, 8'h01, 8'h08, 8'h08);
        drain();
        do_clear(8'h08);
        chk_state("ovr_clr", 8'h01, 8'h00, 8'h00);
        a_i[3] = 1'b1;
        expect_pulse(8'h08, 8'h09, 8'h08, 8'h00);
        drain(); tick(1);
        a_i[3] = 1'b0;
        expect_pulse(8'h08, 8'h01, 8'h08, 8'h00);
        tick(5);
        clear_i = 8'h08;
        tick(1);
        clear_i = 8'h00;
        drain();
        chk_state("set_wins", 8'h01, 8'h08, 8'h00);
        do_clear(8'h08);

        // Mid-count asynchronous reset, then detection restarts from zero.
        set_mode(5, 2'b01);
        a_i[5] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #2;
        chk_state("midrst", 8'h00, 8'h00, 8'h00);
        chk("midrst_pulse", {24'h0, pulse_o}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        expect_pulse(8'h21, 8'h21, 8'h21, 8'h00);
        drain();
        do_clear(8'h21);
        chk_state("post_rst_clr", 8'h21, 8'h00, 8'h00);

        // Staggered toggles on all channels: each pulse 5 edges after its own change.
        mode_i = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            logic [8:0] mask;
            mask = (9'd1 << (i + 1)) - 9'd1;
            a_i[i] = ~a_i[i];
            expect_pulse(8'(9'd1 << i), 8'h21 ^ mask[7:0], mask[7:0], 8'h00);
            tick(1);
        end
        drain();
        chk_state("stagger", 8'hDE, 8'hFF, 8'h00);
        do_clear(8'hFF);
        chk_state("stagger_clr", 8'hDE, 8'h00, 8'h00);

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_capture_bank.md
# edge_capture_bank

Multi-channel, parametrised edge detector with input synchronisation, per-channel debounce, selectable edge mode and sticky W1C pending/overrun flags. It sits between raw asynchronous inputs (buttons, handshake lines, external strobes) and the control logic or interrupt path of the 8-bit core. Every channel produces a one-cycle event pulse, a latched pending bit and a debounced level. A single OR-reduced interrupt line summarises all pending bits.

## Interface
Parameters:
- `CHANNELS`, 8: number of independent input channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised cycles a new level must hold before it is accepted (≥1; 1 = no filtering).

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `a_i`  in  CHANNELS  raw, possibly asynchronous inputs.
- `mode_i`  in  2*CHANNELS  per channel `mode_i[2i+1:2i]`: 00 off, 01 rising, 10 falling, 11 both.
- `clear_i`  in  CHANNELS  write-one-to-clear strobe for pending/overrun of channel i.
- `level_o`  out  CHANNELS  debounced level.
- `pulse_o`  out  CHANNELS  one-cycle pulse on each qualified edge.
- `pending_o`  out  CHANNELS  sticky qualified-edge flag.
- `overrun_o`  out  CHANNELS  sticky flag: qualified edge arrived while pending already set.
- `irq_o`  out  1  OR of all `pending_o` bits.

## Operation
- **Per-channel pipeline:** synchroniser chain, then debounce counter, then debounced level register, then edge qualify, then flags. Channels are fully independent.
- **Debounce.** `cnt` width is clog2(DEBOUNCE_CYCLES), minimum 1.
  - If sync_out == level, cnt ← 0.
  - If sync_out ≠ level and cnt == DEBOUNCE_CYCLES-1, level ← sync_out and cnt ← 0.
  - Otherwise cnt ← cnt+1.
  - Any return to the old level before acceptance discards the count.
- **Raw edges.** A rise is a 0→1 transition of level; a fall is 1→0.
- **Qualified edge:** rise with mode 01/11, or fall with mode 10/11. Mode 00 still tracks `level_o` but never qualifies.
- **Edge outputs:** `pulse_o[i]` is a registered output, high for exactly the cycle in which the new `level_o[i]` is first visible.
- **Pending flag:**
  - A qualified edge sets `pending_o[i]`.
  - `clear_i[i]` clears it.
  - If a qualified edge and a clear occur in the same cycle, set wins.
- **Overrun flag:**
  - A qualified edge with `pending_o[i]`=1 and no same-cycle `clear_i[i]` sets `overrun_o[i]`.
  - `clear_i[i]` clears it, unless that same cycle sets it.
- **Interrupt:** `irq_o` is the combinational OR of the pending flops. It adds no latency and has no glitch-producing inputs.
- **Mode changes:** `mode_i` is sampled each cycle and is not registered. A change takes effect on the next level transition and never generates an edge by itself.
- **Reset:** all synchroniser, counter, level, pulse, pending and overrun flops are cleared to 0. A high input during reset is therefore treated as a rising edge after release.

## Timing
- Reset values: `level_o`, `pulse_o`, `pending_o`, `overrun_o` all 0; `irq_o` = 0.
- Latency: for an input change set up before clock edge k, `level_o`, `pulse_o` and `pending_o` change after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. With the defaults that is edge k+5.
- `pulse_o` width: exactly 1 cycle per accepted transition.
- Minimum accepted pulse: a synchronised level must be held for DEBOUNCE_CYCLES cycles. Shorter glitches produce no level change, pulse or flag.
- `clear_i` takes effect at the next clock edge, so `pending_o` is low the cycle after the strobe.
- `rst_n` asserted mid-operation clears all state immediately (asynchronously), including a partly counted debounce. Deassertion is synchronised externally.

## Test plan
- **Reset-high input:** CHANNELS=8, default params, `a_i`=8'h01 held through reset, mode 01 → on the 6th clock edge after release, `level_o[0]`=1, `pulse_o`=8'h01 for 1 cycle, `pending_o`=8'h01, `irq_o`=1.
- **Glitch rejection and acceptance:** ch2 high for 3 cycles then low → no change on any output. High for 4 cycles → `level_o[2]` rises 5 edges after the input, one pulse.
- **Mode check:** ch1 mode 10, toggle 0→1→0 with 10-cycle holds → only the fall gives a pulse. Mode 11 → two pulses. Mode 00 → `level_o` follows, no pulse or pending.
- **Clear and overrun:**
  - Two qualified edges without clear → `pending_o[3]`=1, `overrun_o[3]`=1.
  - `clear_i`=8'h08 for 1 cycle → both 0, and `irq_o`=0 if no other pending bits are set.
  - `clear_i[3]` in the same cycle as a new pulse → `pending_o[3]` stays 1 and `overrun_o[3]` stays 0.
- **Mid-count reset:** ch5 input changed, `rst_n` pulsed low after 2 debounce cycles → all outputs 0 immediately, and detection restarts from zero after release.
- **Channel independence:** all 8 channels toggled with staggered offsets of 0–7 cycles → each pulse lands exactly 5 edges after its own input change, with no cross-talk.
